// File: rtl/fpu_pkg.sv
// Shared single-precision FPU constants and small helpers used by the
// issue/result pipeline and its FIFO.
package fpu_pkg;

  localparam logic FOP_ADD = 1'b0;
  localparam logic FOP_SUB = 1'b1;

  localparam int unsigned FP_EXP_W    = 8;
  localparam int unsigned FP_MAN_W    = 23;
  localparam int unsigned FP_W        = 1 + FP_EXP_W + FP_MAN_W;
  localparam int unsigned FP_SIGN_BIT = 31;

  localparam logic [FP_W-1:0] FP_ONE = 32'h3F80_0000;

  // FSUB is folded into rs2 as a pure sign flip so NaN payloads pass untouched.
  function automatic logic [FP_W-1:0] fp_apply_op(input logic op,
                                                  input logic [FP_W-1:0] x);
    logic [FP_W-1:0] r;
    r = x;
    r[FP_SIGN_BIT] = x[FP_SIGN_BIT] ^ (op == FOP_SUB);
    return r;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Small synchronous FIFO with async reset and synchronous flush; pointers wrap
// modulo DEPTH, which must be a power of two.
module fpu_sync_fifo #(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full & ~flush;
  assign do_pop   = pop & ~empty & ~flush;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fadd_issue_pipe.sv
// FADD/FSUB issue and result pipeline around the external combinational adder:
// input FIFO -> issue register S0 -> LAT result stages -> backpressured output.
module fadd_issue_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 6,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      core_x1,
  output logic [31:0]      core_x2,
  input  logic [31:0]      core_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned ENTRY_W = 2 * FP_W + TAG_W;
  localparam int unsigned CW      = $clog2(DEPTH + 1);

  logic               advance;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;

  logic               s0_valid;
  logic [FP_W-1:0]    s0_x1;
  logic [FP_W-1:0]    s0_x2;
  logic [TAG_W-1:0]   s0_tag;

  logic               src_valid;
  logic [FP_W-1:0]    src_data;
  logic [TAG_W-1:0]   src_tag;
  logic               pipe_busy;

  assign advance    = ~out_valid | out_ready;
  assign in_ready   = ~fifo_full & ~flush;
  assign fifo_push  = in_valid & in_ready;
  assign fifo_pop   = advance & ~fifo_empty & ~flush;
  assign fifo_wdata = {in_rs1, fp_apply_op(in_op, in_rs2), in_tag};

  fpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_x1    <= '0;
      s0_x2    <= '0;
      s0_tag   <= '0;
    end else if (flush) begin
      s0_valid <= 1'b0;
    end else if (advance) begin
      s0_valid <= ~fifo_empty;
      if (!fifo_empty) {s0_x1, s0_x2, s0_tag} <= fifo_rdata;
    end
  end

  assign core_x1 = s0_valid ? s0_x1 : '0;
  assign core_x2 = s0_valid ? s0_x2 : '0;

  generate
    if (LAT == 0) begin : g_no_pipe
      assign src_valid = s0_valid;
      assign src_data  = core_y;
      assign src_tag   = s0_tag;
      assign pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [LAT-1:0]   p_valid;
      logic [FP_W-1:0]  p_data [LAT];
      logic [TAG_W-1:0] p_tag  [LAT];

      // Stages shift in lockstep with S0; bubbles are carried, never collapsed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          p_valid <= '0;
          for (int unsigned i = 0; i < LAT; i++) begin
            p_data[i] <= '0;
            p_tag[i]  <= '0;
          end
        end else if (flush) begin
          p_valid <= '0;
        end else if (advance) begin
          p_valid[0] <= s0_valid;
          p_data[0]  <= core_y;
          p_tag[0]   <= s0_tag;
          for (int unsigned i = 1; i < LAT; i++) begin
            p_valid[i] <= p_valid[i-1];
            p_data[i]  <= p_data[i-1];
            p_tag[i]   <= p_tag[i-1];
          end
        end
      end

      assign src_valid = p_valid[LAT-1];
      assign src_data  = p_data[LAT-1];
      assign src_tag   = p_tag[LAT-1];
      assign pipe_busy = |p_valid;
    end
  endgenerate

  // A flush drops whatever would have entered the output register this edge,
  // but a result already sitting there is still handed off normally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (advance) begin
      out_valid <= src_valid & ~flush;
      if (src_valid && !flush) begin
        out_data <= src_data;
        out_tag  <= src_tag;
      end
    end
  end

  assign busy = (fifo_count != '0) | s0_valid | pipe_busy | out_valid;

endmodule
